// File: rtl/dino_sound_pkg.sv
// Shared definitions for the dino sound path: jump-trigger FSM states and
// clock/sound timing constants reused by the sound player.
package dino_sound_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FIRE     = 2'b01,
        COOLDOWN = 2'b10
    } jst_state_t;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned JUMP_SOUND_CYCLES = 10_333_354;

endpackage

// File: rtl/jump_sound_trigger_if.sv
// Control/status bundle between the jump-sound front end and its surroundings.
interface jump_sound_trigger_if;

    logic       jump_btn;
    logic       game_active;
    logic       mute;
    logic       jump_event;
    logic       sound_trigger;
    logic       busy;
    logic [7:0] drop_count;

    modport master (
        output jump_btn, game_active, mute,
        input  jump_event, sound_trigger, busy, drop_count
    );

    modport slave (
        input  jump_btn, game_active, mute,
        output jump_event, sound_trigger, busy, drop_count
    );

endinterface

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stable-level counter; clean follows the button
// only after it has held a new level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic clean
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            clean <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // this edge is the DEBOUNCE_CYCLES-th consecutive mismatch
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/jump_sound_trigger.sv
// Jump-sound front end: debounced press detect, one-cycle jump_event, and a
// cooldown-limited sound_trigger with mute/game-active gating and drop count.
module jump_sound_trigger
    import dino_sound_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned COOLDOWN_CYCLES = 10_400_000,
    parameter int unsigned CNT_W           = $clog2(COOLDOWN_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    jump_sound_trigger_if.slave  bus
);

    jst_state_t       state;
    logic             clean;
    logic             clean_q;
    logic             accepted;
    logic [CNT_W-1:0] cd_cnt;
    logic             jump_event_r;
    logic             sound_trigger_r;
    logic             busy_r;
    logic [7:0]       drop_count_r;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.jump_btn),
        .clean(clean)
    );

    assign accepted = clean & ~clean_q & bus.game_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            clean_q         <= 1'b0;
            cd_cnt          <= '0;
            jump_event_r    <= 1'b0;
            sound_trigger_r <= 1'b0;
            busy_r          <= 1'b0;
            drop_count_r    <= '0;
        end else begin
            clean_q         <= clean;
            jump_event_r    <= accepted;
            sound_trigger_r <= 1'b0;
            if (!bus.game_active) begin
                state  <= IDLE;
                cd_cnt <= '0;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accepted && !bus.mute) begin
                            state           <= FIRE;
                            sound_trigger_r <= 1'b1;
                            busy_r          <= 1'b1;
                        end
                    end
                    FIRE: begin
                        cd_cnt <= CNT_W'(COOLDOWN_CYCLES - 1);
                        state  <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (cd_cnt == '0) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            cd_cnt <= cd_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
                if (accepted && !bus.mute && state != IDLE && drop_count_r != 8'hFF)
                    drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end

    assign bus.jump_event    = jump_event_r;
    assign bus.sound_trigger = sound_trigger_r;
    assign bus.busy          = busy_r;
    assign bus.drop_count    = drop_count_r;

endmodule
